// File: rtl/uart_rx_9x8_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_rx_9x8_pkg;

  localparam int C_NDATA = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  // Width of the baud counter for a given bit period in clock cycles.
  function automatic int cnt_width(input int baud_clocks);
    return $clog2(baud_clocks);
  endfunction

endpackage

// File: rtl/uart_rx_9x8_sync.sv
// Multi-stage synchroniser for an asynchronous input; resets to the idle-high level.
module uart_rx_9x8_sync #(
  parameter int G_SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [G_SYNC_STAGES-1:0] sync_q;

  // NOTE: clocked state always uses non-blocking (<=) so every stage samples the pre-edge value.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[G_SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = sync_q[G_SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_9x8.sv
// 8N1 UART receiver: mid-bit sampling, byte holding register with valid/read
// handshake, framing-error and overrun pulses.
module uart_rx_9x8
  import uart_rx_9x8_pkg::*;
#(
  parameter int G_BAUD_CLOCKS = 868,
  parameter int G_SYNC_STAGES = 2,
  parameter int G_NSTOP       = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_UART_Rx,
  input  logic       i_rd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_framing_err,
  output logic       o_overrun
);

  localparam int CW = cnt_width(G_BAUD_CLOCKS);
  localparam logic [CW-1:0] C_HALF = CW'(G_BAUD_CLOCKS / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(G_BAUD_CLOCKS - 1);

  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic          deliver;
  logic          framing_err;

  uart_rx_9x8_sync #(
    .G_SYNC_STAGES(G_SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_async(i_UART_Rx),
    .o_sync (rx_s)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_cnt_d  = stop_cnt_q;
    deliver     = 1'b0;
    framing_err = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = C_HALF;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          state_d = IDLE;  // line went high again before mid-bit: a glitch
        end else begin
          state_d   = DATA;
          cnt_d     = C_FULL;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d   = {rx_s, shift_q[7:1]};
          cnt_d     = C_FULL;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(C_NDATA - 1)) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          framing_err = 1'b1;
          state_d     = WAIT_HIGH;
        end else if (stop_cnt_q == 1'(G_NSTOP - 1)) begin
          deliver = 1'b1;
          state_d = IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
          cnt_d      = C_FULL;
        end
      end
      WAIT_HIGH: begin
        // A break holds the line low; wait it out so it reports only once.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a delivery wins over a read issued in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_framing_err <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_framing_err <= framing_err;
      o_overrun     <= deliver && o_valid && !i_rd;
      if (deliver) begin
        o_data  <= shift_q;
        o_valid <= 1'b1;
      end else if (i_rd) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_9x8.sv
// Directed testbench for uart_rx_9x8: frames, glitch, framing, overrun, read/deliver, reset, rate offset.
module tb_uart_rx_9x8;

  // Bit period scaled down from 868 to keep the run short; 87 keeps an odd half-bit split.
  localparam int C_BAUD    = 87;
  localparam int C_FRAME   = 10 * C_BAUD;
  localparam int C_TIMEOUT = 3 * C_FRAME;
  // Start-bit edge to o_valid rise: sync stages + half bit + 9 bits + 1.
  localparam int C_LATENCY = 2 + C_BAUD / 2 + 9 * C_BAUD + 1;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_UART_Rx = 1'b1;
  logic       i_rd = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_framing_err;
  logic       o_overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int tx_start_cyc = 0;
  int rise_cyc = 0;
  logic valid_prev = 1'b0;

  uart_rx_9x8 #(
    .G_BAUD_CLOCKS(C_BAUD),
    .G_SYNC_STAGES(2),
    .G_NSTOP      (1)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_UART_Rx    (i_UART_Rx),
    .i_rd         (i_rd),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_framing_err(o_framing_err),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    valid_prev <= o_valid;
    if (o_valid && !valid_prev) rise_cyc <= cyc;
    if (o_framing_err) ferr_cnt <= ferr_cnt + 1;
    if (o_overrun) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val,
                            input int bit_cyc, input int stop_cyc);
    tx_start_cyc = cyc;
    i_UART_Rx = 1'b0;
    idle(bit_cyc);
    for (int i = 0; i < 8; i++) begin
      i_UART_Rx = data[i];
      idle(bit_cyc);
    end
    i_UART_Rx = stop_val;
    idle(stop_cyc);
    i_UART_Rx = 1'b1;
  endtask

  task automatic expect_byte(input logic [7:0] exp, input string name);
    int n = 0;
    while (!o_valid && n < C_TIMEOUT) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: o_valid=%b expected 1 within %0d cycles", name, o_valid, C_TIMEOUT);
    end
    checks++;
    if (o_data !== exp) begin
      errors++;
      $display("FAIL %s data: o_data=%02h expected %02h", name, o_data, exp);
    end
    i_rd = 1'b1;
    idle(1);
    i_rd = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s read: o_valid=%b expected 0", name, o_valid);
    end
  endtask

  task automatic expect_counts(input int f0, input int o0, input string name);
    checks++;
    if (ferr_cnt !== f0) begin
      errors++;
      $display("FAIL %s framing pulses: got %0d expected %0d", name, ferr_cnt, f0);
    end
    checks++;
    if (ovr_cnt !== o0) begin
      errors++;
      $display("FAIL %s overrun pulses: got %0d expected %0d", name, ovr_cnt, o0);
    end
  endtask

  task automatic expect_cleared(input string name);
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'h00 || o_framing_err !== 1'b0 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid=%b data=%02h ferr=%b ovr=%b expected 0 00 0 0",
               name, o_valid, o_data, o_framing_err, o_overrun);
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b0;
    i_UART_Rx = 1'b1;
    i_rd = 1'b0;
    idle(4);
    expect_cleared("reset_hold");
    i_rst = 1'b1;
    idle(4);
    expect_cleared("reset_release");
  endtask

  task automatic test_back_to_back;
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    fork
      begin
        // Second start bit begins right after the stop-bit midpoint.
        send_frame(8'h48, 1'b1, C_BAUD, C_BAUD / 2 + 1);
        send_frame(8'h65, 1'b1, C_BAUD, C_BAUD);
      end
      begin
        expect_byte(8'h48, "b2b_first");
        expect_byte(8'h65, "b2b_second");
      end
    join
    idle(C_BAUD);
    expect_counts(f0, o0, "b2b");
  endtask

  task automatic test_glitch;
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    i_UART_Rx = 1'b0;
    idle(C_BAUD / 4);
    i_UART_Rx = 1'b1;
    idle(C_BAUD);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch valid: o_valid=%b expected 0", o_valid);
    end
    expect_counts(f0, o0, "glitch");
    send_frame(8'h6C, 1'b1, C_BAUD, C_BAUD);
    checks++;
    if (rise_cyc - tx_start_cyc < C_LATENCY - 1 || rise_cyc - tx_start_cyc > C_LATENCY + 1) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected %0d +/-1", rise_cyc - tx_start_cyc, C_LATENCY);
    end
    expect_byte(8'h6C, "after_glitch");
    idle(C_BAUD);
  endtask

  task automatic test_framing;
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    // Bad stop bit followed by the line held low for three more bit times.
    send_frame(8'hA5, 1'b0, C_BAUD, 4 * C_BAUD);
    idle(2 * C_BAUD);
    expect_counts(f0 + 1, o0, "framing");
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL framing valid: o_valid=%b expected 0", o_valid);
    end
    send_frame(8'h5A, 1'b1, C_BAUD, C_BAUD);
    expect_byte(8'h5A, "after_framing");
    idle(C_BAUD);
  endtask

  task automatic test_overrun;
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, C_BAUD, C_BAUD);
    idle(C_BAUD);
    send_frame(8'h22, 1'b1, C_BAUD, C_BAUD);
    idle(C_BAUD);
    expect_counts(f0, o0 + 1, "overrun");
    checks++;
    if (o_data !== 8'h22 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun hold: data=%02h valid=%b expected 22 1", o_data, o_valid);
    end
  endtask

  task automatic test_read_on_deliver;
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    fork
      send_frame(8'h33, 1'b1, C_BAUD, C_BAUD);
      begin
        // i_rd high across exactly the delivery edge.
        idle(C_LATENCY - 1);
        i_rd = 1'b1;
        idle(1);
        i_rd = 1'b0;
      end
    join
    checks++;
    if (o_data !== 8'h33 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_deliver: data=%02h valid=%b expected 33 1", o_data, o_valid);
    end
    expect_counts(f0, o0, "rd_deliver");
    i_rd = 1'b1;
    idle(1);
    i_rd = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_clear: o_valid=%b expected 0", o_valid);
    end
    i_rd = 1'b1;
    idle(1);
    i_rd = 1'b0;
    idle(1);
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'h33) begin
      errors++;
      $display("FAIL read_empty: valid=%b data=%02h expected 0 33", o_valid, o_data);
    end
  endtask

  task automatic test_reset_mid_frame;
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    fork
      send_frame(8'hFF, 1'b1, C_BAUD, C_BAUD);
      begin
        idle(5 * C_BAUD + C_BAUD / 2);
        i_rst = 1'b0;
        idle(2);
        expect_cleared("reset_mid_frame");
        i_rst = 1'b1;
      end
    join
    idle(C_BAUD);
    expect_counts(f0, o0, "reset_mid_frame");
    send_frame(8'h0F, 1'b1, C_BAUD, C_BAUD);
    expect_byte(8'h0F, "after_reset");
    idle(C_BAUD);
  endtask

  task automatic test_rate_offset;
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    send_frame(8'h55, 1'b1, C_BAUD + 2, C_BAUD + 2);
    expect_byte(8'h55, "rate_slow");
    idle(C_BAUD);
    send_frame(8'h55, 1'b1, C_BAUD - 2, C_BAUD - 2);
    expect_byte(8'h55, "rate_fast");
    idle(C_BAUD);
    expect_counts(f0, o0, "rate");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_read_on_deliver();
    test_reset_mid_frame();
    test_rate_offset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
